nrzi_deframer: RTL and testbench

Receive-side companion to the NRZI encoder stage. It samples the encoded line one bit at a time, recovers the original bit stream, hunts for a sync pattern, and assembles the next `WIDTH` recovered bits into a parallel word. The word is handed off on a valid/ready interface to the consuming logic. It sits directly downstream of the encoder: its `z` input is the encoder's `z` output.

---
 rtl/nrzi_deframer.sv | 126 ++++++++++++
 tb/tb_nrzi_deframer.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nrzi_deframer.sv
// nrzi_deframer: recovers bits from an NRZI line, hunts for a sync pattern,
// and collects the next WIDTH decoded bits into a word.
//
// Output handshake: a word is transferred at a rising edge where
// data_valid and data_ready are both 1. data_valid stays high and
// data_out stays stable until that transfer happens. A word that
// completes while an untaken word is still held is dropped, and the
// sticky overrun flag is set.
module nrzi_deframer #(
   parameter int                    WIDTH      = 16,
   parameter int                    SYNC_WIDTH = 8,
   parameter logic [SYNC_WIDTH-1:0] SYNC       = 8'h7E,
   parameter logic                  LINE_INIT  = 1'b0
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             z,
   input  logic             bit_en,
   output logic [WIDTH-1:0] data_out,
   output logic             data_valid,
   input  logic             data_ready,
   output logic             locked,
   output logic             overrun
);

   localparam int            CW   = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic {HUNT, COLLECT} state_t;

   state_t                r_state;
   state_t                w_next_state;
   logic                  r_prev_z;
   logic [SYNC_WIDTH-1:0] r_window;
   logic [CW-1:0]         r_count;
   logic [WIDTH-1:0]      r_shift;
   logic [WIDTH-1:0]      r_data;
   logic                  r_valid;
   logic                  r_overrun;

   logic                  w_d;
   logic [SYNC_WIDTH-1:0] w_window_next;
   logic [WIDTH-1:0]      w_shift_next;
   logic                  w_sync_hit;
   logic                  w_complete;

   // A transition on the line is a 1, a steady level is a 0.
   assign w_d           = z ^ r_prev_z;
   assign w_window_next = {r_window[SYNC_WIDTH-2:0], w_d};
   assign w_shift_next  = {r_shift[WIDTH-2:0], w_d};

   // State register.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) r_state <= HUNT;
      else        r_state <= w_next_state;
   end

   // Next state: sync match enters COLLECT, last payload bit returns to HUNT.
   always_comb begin
      w_next_state = r_state;
      w_sync_hit   = 1'b0;
      w_complete   = 1'b0;
      if (bit_en) begin
         case (r_state)
            HUNT: begin
               if (w_window_next == SYNC) begin
                  w_sync_hit   = 1'b1;
                  w_next_state = COLLECT;
               end
            end
            COLLECT: begin
               if (r_count == LAST) begin
                  w_complete   = 1'b1;
                  w_next_state = HUNT;
               end
            end
            default: w_next_state = HUNT;
         endcase
      end
   end

   // Line history, sync window, payload shifter and bit counter; all stall when bit_en=0.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_prev_z <= LINE_INIT;
         r_window <= '0;
         r_count  <= '0;
         r_shift  <= '0;
      end else if (bit_en) begin
         r_prev_z <= z;
         if (r_state == HUNT) begin
            r_window <= w_window_next;
            if (w_sync_hit) r_count <= '0;
         end else begin
            r_shift <= w_shift_next;
            r_count <= r_count + 1'b1;
            // The next word needs a freshly received sync.
            if (w_complete) r_window <= '0;
         end
      end
   end

   // Output holding register with valid/ready handshake and sticky overrun.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_data    <= '0;
         r_valid   <= 1'b0;
         r_overrun <= 1'b0;
      end else if (w_complete) begin
         if (!r_valid || data_ready) begin
            r_data  <= w_shift_next;
            r_valid <= 1'b1;
         end else begin
            r_overrun <= 1'b1;
         end
      end else if (r_valid && data_ready) begin
         r_valid <= 1'b0;
      end
   end

   assign data_out   = r_data;
   assign data_valid = r_valid;
   assign overrun    = r_overrun;
   assign locked     = (r_state == COLLECT);

endmodule

// File: tb/tb_nrzi_deframer.sv
// tb_nrzi_deframer: randomized and directed stimulus against a bit-level
// behavioural model of the deframer, plus a word scoreboard on the handshake.
module tb_nrzi_deframer;

  localparam logic [7:0] SYNC_P = 8'h7E;

  logic        clock;
  logic        reset;
  logic        z;
  logic        bit_en;
  logic [15:0] data_out;
  logic        data_valid;
  logic        data_ready;
  logic        locked;
  logic        overrun;

  nrzi_deframer #(
    .WIDTH(16), .SYNC_WIDTH(8), .SYNC(8'h7E), .LINE_INIT(1'b0)
  ) dut (
    .clock(clock), .reset(reset), .z(z), .bit_en(bit_en),
    .data_out(data_out), .data_valid(data_valid), .data_ready(data_ready),
    .locked(locked), .overrun(overrun)
  );

  // ---------------- clock ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int lock_cnt = 0;
  int valid_cnt = 0;
  int xfer_cnt = 0;
  int rise_cyc = 0;
  logic [15:0] rise_word = '0;
  logic        last_valid = 1'b0;
  logic [15:0] last_out = '0;
  bit          rnd_rdy = 1'b0;

  logic [15:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // Works on the decoded bit sequence: the last 8 decoded bits as a number
  // while hunting, and a list of collected payload bits while locked.
  bit          m_prev;
  bit          m_hunt;
  int          m_win;
  bit          m_bits[$];
  logic [15:0] m_out;
  bit          m_valid;
  bit          m_over;

  task automatic model_reset();
    m_prev = 1'b0;
    m_hunt = 1'b1;
    m_win = 0;
    m_bits.delete();
    m_out = '0;
    m_valid = 1'b0;
    m_over = 1'b0;
    exp_q.delete();
    last_valid = 1'b0;
    last_out = '0;
  endtask

  task automatic model_step();
    bit d;
    bit done;
    bit xfer;
    logic [15:0] word;
    done = 1'b0;
    word = '0;
    xfer = m_valid && data_ready;
    if (bit_en) begin
      d = z ^ m_prev;
      m_prev = z;
      if (m_hunt) begin
        m_win = (m_win * 2 + int'(d)) % 256;
        if (m_win == int'(SYNC_P)) begin
          m_hunt = 1'b0;
          m_bits.delete();
        end
      end else begin
        m_bits.push_back(d);
        if (m_bits.size() == 16) begin
          foreach (m_bits[i]) word = {word[14:0], m_bits[i]};
          done = 1'b1;
          m_hunt = 1'b1;
          m_win = 0;
        end
      end
    end
    if (done) begin
      if (!m_valid || data_ready) begin
        m_out = word;
        m_valid = 1'b1;
        exp_q.push_back(word);
      end else begin
        m_over = 1'b1;
      end
    end else if (xfer) begin
      m_valid = 1'b0;
    end
  endtask

  // ---------------- compare process ----------------
  always begin
    @(posedge clock);
    if (reset && last_valid && data_ready) begin
      if (exp_q.size() == 0) check("sb_unexpected_word", 32'(last_out), 32'hDEAD_BEEF);
      else check("sb_word", 32'(last_out), 32'(exp_q.pop_front()));
      xfer_cnt++;
    end
    if (!reset) model_reset();
    else model_step();
    #1;
    cyc++;
    check("data_out",   32'(data_out),   32'(m_out));
    check("data_valid", 32'(data_valid), 32'(m_valid));
    check("locked",     32'(locked),     32'(!m_hunt));
    check("overrun",    32'(overrun),    32'(m_over));
    if (locked) lock_cnt++;
    if (data_valid) valid_cnt++;
    if (data_valid && !last_valid) begin
      rise_cyc = cyc;
      rise_word = data_out;
    end
    last_valid = data_valid;
    last_out = data_out;
  end

  // ---------------- driver tasks ----------------
  task automatic send_bit(input logic d, input int gap);
    z = z ^ d;
    bit_en = 1'b1;
    if (rnd_rdy) data_ready = 1'($urandom_range(0, 1));
    @(negedge clock);
    bit_en = 1'b0;
    repeat (gap) begin
      if (rnd_rdy) data_ready = 1'($urandom_range(0, 1));
      @(negedge clock);
    end
  endtask

  task automatic send_sync(input int gap);
    for (int i = 7; i >= 0; i--) send_bit(SYNC_P[i], gap);
  endtask

  task automatic send_frame(input logic [15:0] w, input int gap);
    send_sync(gap);
    for (int i = 15; i >= 0; i--) send_bit(w[i], gap);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  // ---------------- stimulus ----------------
  int t0;
  int x0;
  logic [15:0] wb;

  initial begin
    reset = 1'b0;
    z = 1'b0;
    bit_en = 1'b0;
    data_ready = 1'b0;
    model_reset();
    idle(3);
    check("rst_data_out",   32'(data_out),   32'h0);
    check("rst_data_valid", 32'(data_valid), 32'h0);
    check("rst_locked",     32'(locked),     32'h0);
    check("rst_overrun",    32'(overrun),    32'h0);
    reset = 1'b1;
    idle(2);

    // Basic word, one bit per clock.
    data_ready = 1'b1;
    lock_cnt = 0;
    valid_cnt = 0;
    t0 = cyc;
    send_frame(16'hF161, 0);
    idle(3);
    check("basic_lock_clocks", 32'(lock_cnt), 32'd16);
    check("basic_valid_clocks", 32'(valid_cnt), 32'd1);
    check("basic_word", 32'(rise_word), 32'hF161);
    check("basic_latency", 32'(rise_cyc - t0), 32'd24);
    check("basic_overrun", 32'(overrun), 32'h0);

    // Gapped input: bit_en 1,0,1,0...
    t0 = cyc;
    send_frame(16'hCF0C, 1);
    idle(3);
    check("gap_word", 32'(rise_word), 32'hCF0C);
    check("gap_latency", 32'(rise_cyc - t0), 32'd47);

    // Back-pressure and overrun.
    data_ready = 1'b0;
    send_frame(16'h8C00, 0);
    send_frame(16'hF161, 0);
    idle(2);
    check("bp_word_held", 32'(data_out), 32'h8C00);
    check("bp_valid_held", 32'(data_valid), 32'h1);
    check("bp_overrun", 32'(overrun), 32'h1);
    data_ready = 1'b1;
    idle(1);
    check("bp_valid_drop", 32'(data_valid), 32'h0);

    // Transfer of A and completion of B at the same edge.
    data_ready = 1'b0;
    send_frame(16'h1234, 0);
    wb = 16'hBEEF;
    send_sync(0);
    for (int i = 15; i >= 1; i--) send_bit(wb[i], 0);
    data_ready = 1'b1;
    send_bit(wb[0], 0);
    check("simul_word", 32'(data_out), 32'hBEEF);
    check("simul_valid", 32'(data_valid), 32'h1);
    idle(2);

    // Hunt robustness: sync-free noise, sync, payload that looks like sync.
    x0 = xfer_cnt;
    for (int i = 0; i < 20; i++) send_bit((i % 4 == 3) ? 1'b0 : 1'($urandom_range(0, 1)), 0);
    send_frame(16'h7E7E, 0);
    for (int i = 0; i < 20; i++) send_bit((i % 4 == 3) ? 1'b0 : 1'($urandom_range(0, 1)), 0);
    idle(3);
    check("hunt_one_word", 32'(xfer_cnt - x0), 32'd1);
    check("hunt_word", 32'(rise_word), 32'h7E7E);

    // Reset in the middle of a payload.
    data_ready = 1'b0;
    send_sync(0);
    for (int i = 0; i < 10; i++) send_bit(1'($urandom_range(0, 1)), 0);
    #2;
    reset = 1'b0;
    z = 1'b0;
    model_reset();
    #1;
    check("midrst_data_out", 32'(data_out), 32'h0);
    check("midrst_valid", 32'(data_valid), 32'h0);
    check("midrst_locked", 32'(locked), 32'h0);
    check("midrst_overrun", 32'(overrun), 32'h0);
    idle(3);
    reset = 1'b1;
    data_ready = 1'b1;
    send_frame(16'hA5C3, 0);
    idle(2);
    check("midrst_after_word", 32'(rise_word), 32'hA5C3);

    // Randomized frames, noise, gaps and consumer stalls.
    rnd_rdy = 1'b1;
    for (int f = 0; f < 25; f++) begin
      int nn;
      int g;
      nn = $urandom_range(0, 12);
      g = $urandom_range(0, 2);
      for (int i = 0; i < nn; i++) send_bit(1'($urandom_range(0, 1)), $urandom_range(0, 2));
      send_frame(16'($urandom), g);
    end
    rnd_rdy = 1'b0;
    data_ready = 1'b1;
    idle(4);
    check("drain_queue_empty", 32'(exp_q.size()), 32'd0);
    check("drain_valid", 32'(data_valid), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
